timer_dev: RTL

- Memory-mapped timer that responds on the processor's data bus (address / write-enable / byte-enable / write-data in, read-data out).
- Drives one bit of the processor's HWInt interrupt vector.
- Instantiated behind the system bridge, alongside other memory-mapped devices.
- Three 32-bit registers: CTRL (0x0), PRESET (0x4), COUNT (0x8, read-only).
- Down-counts with a 4-state FSM; one-shot and auto-reload modes.

---
 rtl/timer_dev.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/timer_dev.sv
// Memory-mapped down-counting timer: CTRL / PRESET / COUNT registers, one-shot or auto-reload, one IRQ line.
// Optional macro TIMER_PRESCALE_EN turns offset 3 into a PRESCALE register that slows the count.
module timer_dev #(
  parameter logic [31:0] BASE = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        irq
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  state_t      state;
  logic [3:0]  ctrl;      // [0] EN, [2:1] MODE, [3] IM
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_flag;

  logic [1:0]  offset;
  logic        wr;
  logic        ctrl_wr;
  logic        preset_wr;
  logic        auto_reload;
  logic        tick;
  logic        unused_addr;

  assign offset      = addr[3:2];
  assign hit         = (addr[31:4] == BASE[31:4]);
  assign wr          = hit && we && (byteen != 4'b0000);
  assign ctrl_wr     = wr && (offset == 2'd0);
  assign preset_wr   = wr && (offset == 2'd1);
  assign auto_reload = (ctrl[2:1] == 2'b01);
  assign irq         = irq_flag & ctrl[3];
  assign unused_addr = &{1'b0, addr[1:0]};

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

`ifdef TIMER_PRESCALE_EN
  logic [31:0] prescale;
  logic [31:0] pcnt;
  logic        prescale_wr;

  assign prescale_wr = wr && (offset == 2'd3);
  assign tick        = (pcnt == prescale);

  // Prescale counter only runs while actively counting; everywhere else it restarts from 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescale <= '0;
      pcnt     <= '0;
    end else begin
      if (state == CNT && ctrl[0]) begin
        pcnt <= tick ? 32'd0 : pcnt + 32'd1;
      end else begin
        pcnt <= '0;
      end
      if (prescale_wr) prescale <= merge_bytes(prescale, wdata, byteen);
    end
  end
`else
  assign tick = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
    end else begin
      // Any CTRL/PRESET write acknowledges the interrupt; a terminal count below overrides it.
      if (ctrl_wr || preset_wr) irq_flag <= 1'b0;

      case (state)
        IDLE: begin
          if (ctrl[0]) state <= LOAD;
        end
        LOAD: begin
          count <= preset;
          state <= CNT;
        end
        CNT: begin
          if (!ctrl[0]) begin
            state <= IDLE;
          end else if (tick) begin
            if (count > 32'd1) begin
              count <= count - 32'd1;
            end else begin
              count    <= '0;
              irq_flag <= 1'b1;
              state    <= INT;
            end
          end
        end
        INT: begin
          if (auto_reload) begin
            irq_flag <= 1'b0;
            state    <= LOAD;
          end else begin
            ctrl[0] <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Bus writes come last so a simultaneous CTRL write beats the one-shot EN clear.
      if (ctrl_wr && byteen[0]) ctrl <= wdata[3:0];
      if (preset_wr) preset <= merge_bytes(preset, wdata, byteen);
    end
  end

  always_comb begin
    rdata = '0;
    if (hit) begin
      case (offset)
        2'd0: rdata = {28'd0, ctrl};
        2'd1: rdata = preset;
        2'd2: rdata = count;
`ifdef TIMER_PRESCALE_EN
        2'd3: rdata = prescale;
`else
        2'd3: rdata = '0;
`endif
        default: rdata = '0;
      endcase
    end
  end

endmodule
